display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Scan timing generator for the multiplexed 8-digit 7-segment display.
- Sits directly upstream of the TDM digit/anode multiplexer and drives its 3-bit digit-select `count`.
- Also produces a `blank` qualifier, which forces all anodes off during inter-digit dead-time and during optional brightness-PWM off-phases, and a once-per-frame tick.
- Replaces the free-running counter in the top level.

Parameters:
- DIV, 50000: clock cycles per digit slot; legal range DIV >= 2.
- DEAD, 16: blanked cycles at the start of every slot, for ghost suppression; legal range 0 <= DEAD < DIV.
- NUM_DIGITS, 8: number of digits scanned; legal range 1..8. The digit index wraps at NUM_DIGITS-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable. While low, the scan is held at digit 0, slot start, and blanked.
- brightness, input, 4: PWM duty code. 15 = full on. Used only with SCAN_BRIGHTNESS_EN.
- count, output, 3: digit index to the TDM; registered.
- blank, output, 1: 1 = all anodes must be off. Registered. The top level ORs it into the anodes: anodes | {8{blank}}.
- frame_tick, output, 1: one-cycle pulse in the cycle `count` returns to 0 after a full frame.

Behaviour:
- Internal state:
  - slot_cnt, width $clog2(DIV), counts 0..DIV-1.
  - digit register driving `count`.
  - No other state except the PWM phase (derived, see Optional Feature).
- Reset (rst=1 at a clk edge), next cycle:
  - slot_cnt=0, count=0, blank=1, frame_tick=0.
  - rst has priority over en.
  - Reset mid-slot or mid-frame discards progress with no partial tick.
- en=0 at a clk edge, next cycle:
  - slot_cnt=0, count=0, blank=1, frame_tick=0.
- en=1:
  - slot_cnt increments every cycle.
  - When slot_cnt==DIV-1: slot_cnt goes to 0, and count goes to 0 if count==NUM_DIGITS-1, otherwise count+1.
- frame_tick:
  - Is 1 exactly in the cycle whose registered count becomes 0 through the wrap.
  - Is never asserted on reset or on en release.
  - With NUM_DIGITS=1 it pulses every DIV cycles.
- blank is registered and computed from next-state values, so in any cycle it matches the current slot_cnt/count. No combinational path from inputs to outputs.
- blank=1 when any of:
  - en_q==0;
  - slot_cnt < DEAD;
  - the PWM off-phase applies (feature only).
- Otherwise blank=0.
- Timing guarantees:
  - A change of count is always accompanied by blank=1 when DEAD >= 1.
  - DEAD=0 means no dead-time.
- First cycle after en rises (from 0 to 1):
  - slot_cnt=0, count=0.
  - blank follows the rules above, with en_q=1 from that cycle.
- Widths: slot_cnt compare is done at full width. DIV not a power of two must wrap exactly at DIV-1.

Optional Feature:
- Macro: SCAN_BRIGHTNESS_EN.
- Defined:
  - phase = (slot_cnt - DEAD) mod 16, using the low 4 bits.
  - In the lit region (slot_cnt >= DEAD), blank is also 1 when phase > brightness.
  - brightness=15 gives full duty; brightness=0 gives 1/16 duty.
  - brightness is sampled every cycle; a mid-slot change takes effect on the next cycle.
- Undefined:
  - brightness is ignored (port kept, unused).
  - blank depends only on en and DEAD.

Test Plan:
- DIV=8, DEAD=2, NUM_DIGITS=8, en=1 after rst -> count steps 0,1,…,7,0 every 8 cycles. Within each slot, blank=1 on slot cycles 0–1 and 0 on cycles 2–7. frame_tick pulses once every 64 cycles, coincident with count=0.
- NUM_DIGITS=6, DIV=5, DEAD=1 -> count sequence 0..5 then 0, never reaching 6 or 7. frame_tick period is 30 cycles.
- en dropped at slot cycle 4 of digit 3 for 3 cycles, then raised -> next cycle count=0 and blank=1. frame_tick stays 0. Scan restarts at digit 0, slot 0.
- rst asserted for 1 cycle mid-frame (count=5) with en=1 -> next cycle count=0, blank=1, frame_tick=0. Normal scanning resumes with no spurious tick.
- SCAN_BRIGHTNESS_EN, DIV=40, DEAD=2, brightness=3 -> within a slot, blank=0 only on slot cycles 2–5, 18–21 and 34–37. brightness=15 -> blank=0 on cycles 2–39.
- DEAD=0, DIV=2, NUM_DIGITS=1 -> blank stays 0 with en=1. count stays 0. frame_tick pulses every 2 cycles.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scan timing generator for a multiplexed 7-segment display: digit select, anode blanking, frame tick.
// Latency: all outputs registered; a sampled input affects the outputs in the following cycle.
// Backpressure: none; i_en holds the scan at digit 0 / slot start with the anodes blanked.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset (priority over i_en)
//   i_en         scan enable; low holds the scan at digit 0, slot start, blanked
//   i_brightness PWM duty code, 15 = full on (only used with SCAN_BRIGHTNESS_EN)
//   o_count      registered digit index for the TDM multiplexer
//   o_blank      registered "all anodes off" qualifier, consistent with o_count
//   o_frame_tick one-cycle pulse in the cycle o_count wraps back to 0
//
// Optional feature macro: SCAN_BRIGHTNESS_EN (brightness PWM inside the lit part of each slot).
module display_scan_ctrl #(
    parameter int DIV        = 50000,
    parameter int DEAD       = 16,
    parameter int NUM_DIGITS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_brightness,
    output logic [2:0] o_count,
    output logic       o_blank,
    output logic       o_frame_tick
);

    localparam int              SW         = $clog2(DIV);
    localparam logic [SW-1:0]   SLOT_LAST  = SW'(DIV - 1);
    localparam logic [SW-1:0]   SLOT_ONE   = SW'(1);
    localparam logic [SW-1:0]   DEAD_W     = SW'(DEAD);
    localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [SW-1:0] r_slot_cnt;
    logic [2:0]    r_count;
    logic          r_blank;
    logic          r_frame_tick;
    logic          r_en_q;

    logic [SW-1:0] w_slot_nxt;
    logic [2:0]    w_count_nxt;
    logic          w_tick_nxt;
    logic          w_en_q_nxt;
    logic          w_in_dead;
    logic          w_pwm_off;
    logic          w_blank_nxt;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot_cnt   <= '0;
            r_count      <= '0;
            r_blank      <= 1'b1;
            r_frame_tick <= 1'b0;
            r_en_q       <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_nxt;
            r_count      <= w_count_nxt;
            r_blank      <= w_blank_nxt;
            r_frame_tick <= w_tick_nxt;
            r_en_q       <= w_en_q_nxt;
        end
    end

    // Next-state logic. The first enabled cycle after a hold (or reset) starts
    // the scan at slot 0 of digit 0 rather than advancing past it.
    always_comb begin
        w_slot_nxt  = '0;
        w_count_nxt = '0;
        w_tick_nxt  = 1'b0;
        w_en_q_nxt  = 1'b0;
        if (i_rst || !i_en) begin
            w_en_q_nxt = 1'b0;
        end else if (!r_en_q) begin
            w_en_q_nxt = 1'b1;
        end else begin
            w_en_q_nxt = 1'b1;
            if (r_slot_cnt == SLOT_LAST) begin
                w_slot_nxt = '0;
                if (r_count == DIGIT_LAST) begin
                    w_count_nxt = '0;
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + 3'd1;
                end
            end else begin
                w_slot_nxt  = r_slot_cnt + SLOT_ONE;
                w_count_nxt = r_count;
            end
        end
    end

    // Dead-time at the start of each slot; DEAD=0 disables it without a
    // degenerate "less than zero" compare.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign w_in_dead = 1'b0;
        end else begin : g_dead
            assign w_in_dead = (w_slot_nxt < DEAD_W);
        end
    endgenerate

`ifdef SCAN_BRIGHTNESS_EN
    localparam logic [31:0] DEAD_U = DEAD;
    logic [3:0] w_phase;

    // PWM phase counts from the end of the dead-time, repeating every 16 cycles.
    assign w_phase   = 4'(32'(w_slot_nxt) - DEAD_U);
    assign w_pwm_off = !w_in_dead && (w_phase > i_brightness);
`else
    logic w_unused_brightness;

    assign w_unused_brightness = ^i_brightness;
    assign w_pwm_off           = 1'b0;
`endif

    // Output comb: blank is derived from next-state values so the registered
    // copy always matches the registered slot/count it accompanies.
    assign w_blank_nxt = !w_en_q_nxt || w_in_dead || w_pwm_off;

    assign o_count      = r_count;
    assign o_blank      = r_blank;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic rst_a = 1'b1, en_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0;
    logic rst_c = 1'b1, en_c = 1'b0;
    logic rst_d = 1'b1, en_d = 1'b0;
    logic [3:0] bright_full = 4'hF;
    logic [3:0] bright_d    = 4'd3;

    logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic blank_a, blank_b, blank_c, blank_d;
    logic tick_a, tick_b, tick_c, tick_d;

    display_scan_ctrl #(.DIV(8), .DEAD(2), .NUM_DIGITS(8)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .i_brightness(bright_full),
        .o_count(cnt_a), .o_blank(blank_a), .o_frame_tick(tick_a));
    display_scan_ctrl #(.DIV(5), .DEAD(1), .NUM_DIGITS(6)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .i_brightness(bright_full),
        .o_count(cnt_b), .o_blank(blank_b), .o_frame_tick(tick_b));
    display_scan_ctrl #(.DIV(2), .DEAD(0), .NUM_DIGITS(1)) dut_c (
        .i_clk(clk), .i_rst(rst_c), .i_en(en_c), .i_brightness(bright_full),
        .o_count(cnt_c), .o_blank(blank_c), .o_frame_tick(tick_c));
    display_scan_ctrl #(.DIV(40), .DEAD(2), .NUM_DIGITS(2)) dut_d (
        .i_clk(clk), .i_rst(rst_d), .i_en(en_d), .i_brightness(bright_d),
        .o_count(cnt_d), .o_blank(blank_d), .o_frame_tick(tick_d));

    // Model: t = cycles since the scan (re)started, -1 while held.
    int ta = -1, tb = -1, tc = -1, td = -1;
    logic [3:0] bq_d = 4'd3;
    always @(posedge clk) begin
        ta   <= (rst_a || !en_a) ? -1 : ta + 1;
        tb   <= (rst_b || !en_b) ? -1 : tb + 1;
        tc   <= (rst_c || !en_c) ? -1 : tc + 1;
        td   <= (rst_d || !en_d) ? -1 : td + 1;
        bq_d <= bright_d;
    end

    // Expected {count, blank, frame_tick} from elapsed scan time.
    function automatic logic [4:0] expect_out(int t, int div, int dead, int nd, logic [3:0] bq);
        int slot, dig;
        logic bl, tk;
        if (t < 0) return 5'b000_1_0;
        slot = t % div;
        dig  = (t / div) % nd;
        tk   = (t > 0) && (slot == 0) && (dig == 0);
        bl   = (slot < dead);
`ifdef SCAN_BRIGHTNESS_EN
        if (slot >= dead && ((slot - dead) % 16) > int'(bq)) bl = 1'b1;
`endif
        return {3'(dig), bl, tk};
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got {count,blank,tick}=%b required %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Traces gathered from the DUTs for the literal checks.
    logic chk_on = 1'b0;
    logic [7:0] mask_a = '0;
    int first_tick_a = -1, first_tick_b = -1, first_tick_c = -1;
    int last_tick_a = -1;
    int max_cnt_b = 0, tick_cnt_b = 0, tick_cnt_c = 0;
    int lit_d1 = 0, lit_d2 = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_a", {cnt_a, blank_a, tick_a}, expect_out(ta, 8, 2, 8, 4'hF));
            check("model_b", {cnt_b, blank_b, tick_b}, expect_out(tb, 5, 1, 6, 4'hF));
            check("model_c", {cnt_c, blank_c, tick_c}, expect_out(tc, 2, 0, 1, 4'hF));
            check("model_d", {cnt_d, blank_d, tick_d}, expect_out(td, 40, 2, 2, bq_d));
            if (ta >= 0 && ta < 8) mask_a[ta] = blank_a;
            if (tick_a && first_tick_a < 0) first_tick_a = ta;
            if (tick_a) last_tick_a = ta;
            if (tick_b && first_tick_b < 0) first_tick_b = tb;
            if (tick_c && first_tick_c < 0) first_tick_c = tc;
            if (tb >= 0 && int'(cnt_b) > max_cnt_b) max_cnt_b = int'(cnt_b);
            if (tick_b && tb >= 0 && tb <= 160) tick_cnt_b++;
            if (tick_c && tc >= 0 && tc <= 20) tick_cnt_c++;
            if (td >= 40 && td < 80 && !blank_d) lit_d1++;
            if (td >= 120 && td < 160 && !blank_d) lit_d2++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;

        // Reset everything.
        step(3);
        chk_on = 1'b1;
        check("reset_a", {cnt_a, blank_a, tick_a}, 5'b000_1_0);
        check("reset_d", {cnt_d, blank_d, tick_d}, 5'b000_1_0);

        // Free-running scan on all instances.
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
        en_a = 1; en_b = 1; en_c = 1; en_d = 1;
        for (int i = 0; i < 175; i++) begin
            step(1);
            if (td == 100) bright_d = 4'd15;
        end
        #1;
        check_int("slot_blank_mask_a", int'(mask_a), 3);
        check_int("first_tick_a", first_tick_a, 64);
        check_int("first_tick_b", first_tick_b, 30);
        check_int("first_tick_c", first_tick_c, 2);
        check_int("max_count_b", max_cnt_b, 5);
        check_int("tick_count_b", tick_cnt_b, 5);
        check_int("tick_count_c", tick_cnt_c, 10);
`ifdef SCAN_BRIGHTNESS_EN
        check_int("lit_cycles_d_b3", lit_d1, 12);
`else
        check_int("lit_cycles_d_b3", lit_d1, 38);
`endif
        check_int("lit_cycles_d_b15", lit_d2, 38);

        // Drop en at digit 3, slot cycle 4 for three cycles.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (ta >= 0 && (ta % 64) == 28) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_en_drop: target slot not reached in 200 cycles");
        end
        en_a = 0;
        step(1);
        check("en_low_a", {cnt_a, blank_a, tick_a}, 5'b000_1_0);
        step(2);
        en_a = 1;
        step(1);
        check("en_restart_a", {cnt_a, blank_a, tick_a}, 5'b000_1_0);

        // One-cycle reset at count 5.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (ta >= 0 && (ta % 64) == 43) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_mid_rst: target slot not reached in 200 cycles");
        end
        check_int("pre_rst_count_a", int'(cnt_a), 5);
        rst_a = 1;
        step(1);
        rst_a = 0;
        check("mid_rst_a", {cnt_a, blank_a, tick_a}, 5'b000_1_0);
        last_tick_a = -1;
        step(80);
        #1;
        check_int("tick_after_rst_a", last_tick_a, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
